// File: rtl/hs32_imem.sv
// hs32_imem: fetch-side instruction memory responder (one request at a time, programmable wait states).
// Define HS32_IMEM_FAULT_EN to add the sticky out-of-range `fault` output.
module hs32_imem #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic        reqm,
    output logic        rdym,
    output logic [31:0] dtr,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    output logic        busy
`ifdef HS32_IMEM_FAULT_EN
    ,
    output logic        fault
`endif
);
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WCNT_INIT = 4'(WAIT_STATES);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range
            $error("hs32_imem: WAIT_STATES must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:2] a_q, a_d;
    logic [31:0] dtr_q;
    logic [31:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] ridx, widx;
    logic                  rd_in_range, wr_in_range;
    logic                  unused_low_bits;

    assign ridx            = a_q[DEPTH_LOG2+1:2];
    assign widx            = waddr[DEPTH_LOG2+1:2];
    assign rd_in_range     = (a_q[31:DEPTH_LOG2+2] == '0);
    assign wr_in_range     = (waddr[31:DEPTH_LOG2+2] == '0);
    assign unused_low_bits = ^{addr[1:0], waddr[1:0]};

    // Request is latched once in IDLE; RESP always returns to IDLE without sampling reqm.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        a_d     = a_q;
        case (state_q)
            S_IDLE: begin
                if (reqm) begin
                    a_d     = addr[31:2];
                    wcnt_d  = WCNT_INIT;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_READ;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            a_q     <= '0;
            dtr_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            a_q     <= a_d;
            if (state_q == S_READ) begin
                dtr_q <= rd_in_range ? mem[ridx] : '0;
            end
        end
    end

    // No reset on the array: the program image survives rstn.
    always_ff @(posedge clk) begin
        if (we && wr_in_range) begin
            mem[widx] <= wdata;
        end
    end

`ifdef HS32_IMEM_FAULT_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_q <= 1'b0;
        end else if ((state_q == S_READ && !rd_in_range) || (we && !wr_in_range)) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`endif

    assign rdym = (state_q == S_RESP);
    assign busy = (state_q != S_IDLE);
    assign dtr  = dtr_q;

endmodule
